cpu_mem_responder: RTL and testbench
====================================

Name: cpu_mem_responder

Overview:
- Memory-side responder for the 5-stage pipelined CPU's instruction and data ports.
- Holds a unified word-addressed RAM.
- Serves instruction fetches and data reads combinationally; commits data writes on the clock edge.
- Adds a valid/ready preload port with an FSM that holds the CPU while a program image is loaded.
- Adds access counters and sticky error flags for verification and debug.

Parameters:
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two, >= 4.
- AW, 10: word-index width, equal to log2(DEPTH_WORDS).
- CNT_W, 16: width of the access counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- instr_addr  in  32  CPU fetch byte address
- instruction  out  32  fetched word
- data_addr  in  32  CPU data byte address
- data_out  in  32  CPU store data
- data_in  out  32  load data returned to CPU
- mem_write  in  1  CPU store strobe
- mem_read  in  1  CPU load strobe
- ld_start  in  1  begin preload session
- ld_valid  in  1  preload word valid
- ld_ready  out  1  responder accepts preload word
- ld_addr  in  AW  preload word index
- ld_data  in  32  preload word
- ld_last  in  1  final word of session
- ld_done  out  1  one-cycle pulse when session ends
- cpu_hold  out  1  CPU must be held in reset while high
- rd_count  out  CNT_W  CPU loads serviced
- wr_count  out  CNT_W  CPU stores committed
- misalign_err  out  1  sticky: data access with addr[1:0] != 0
- bounds_err  out  1  sticky: out-of-range access (optional feature)

Behaviour:
- Reset values: FSM=IDLE, ld_ready=0, ld_done=0, cpu_hold=0, rd_count=0, wr_count=0, misalign_err=0, bounds_err=0.
- RAM contents are not cleared by rst; they survive reset.
- Word index is addr[AW+1:2] on both CPU ports.
- Fetch: instruction = RAM[instr index], combinational, zero latency.
  - While cpu_hold=1, instruction = 32'h0 (pipeline NOP).
- Data read: data_in = RAM[data index], combinational. This matches the CPU sampling data_in into MEM/WB on the same edge.
  - data_in = 32'h0 when mem_read=0 or cpu_hold=1.
- Data write: on posedge when mem_write=1, cpu_hold=0 and data_addr[1:0]==0, RAM[index] <= data_out.
- Simultaneous mem_read and mem_write to the same word: data_in returns the old word (read-before-write), and the write commits at the edge.
- Misaligned access (mem_read or mem_write with addr[1:0] != 0):
  - the write is suppressed;
  - a read returns the aligned word;
  - misalign_err is set and stays set until rst.
- Counters:
  - rd_count increments on each cycle with mem_read=1 and cpu_hold=0.
  - wr_count increments on each committed write.
  - Both saturate at all-ones and do not wrap.
  - A misaligned write does not increment wr_count.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: ld_ready=0, cpu_hold=0. ld_start=1 -> LOAD.
  - LOAD: ld_ready=1, cpu_hold=1. Each cycle with ld_valid=1 writes RAM[ld_addr] <= ld_data at the edge. If ld_last=1 in the same beat -> DONE. ld_valid=0 means no write, stay in LOAD.
  - DONE: ld_ready=0, cpu_hold=1, ld_done=1 for exactly one cycle -> IDLE.
- ld_start is ignored outside IDLE.
- ld_valid outside LOAD is ignored and no write occurs.
- CPU mem_write during LOAD/DONE is dropped and not counted.
- rst asserted mid-LOAD: FSM returns to IDLE immediately; no ld_done pulse; words already written remain in RAM.
- Preload beat and CPU write to the same word in the same cycle cannot occur, because CPU writes are blocked while cpu_hold=1.

Optional Feature:
- Macro: MEM_BOUNDS_CHECK_EN.
- Defined: any CPU access whose byte address is >= DEPTH_WORDS*4 has these effects:
  - the write is suppressed and not counted;
  - a read returns 32'hDEADBEEF on data_in (or on instruction, for a fetch);
  - bounds_err is set and is sticky until rst.
- Not defined: upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS, and bounds_err is tied to 0.

Test Plan:
- Reset then idle: all outputs at reset values; instruction at addr 0x0 reflects prior RAM content (not cleared).
- Preload: ld_start, then 3 beats idx 0,1,2 with data 0x00500093, 0x00100113, 0x002081B3, ld_last on beat 3 -> cpu_hold=1 from the cycle after ld_start through DONE; ld_done pulses once; fetch 0x8 returns 0x002081B3.
- Store then load: mem_write addr 0x40 data 0xCAFEF00D, next cycle mem_read addr 0x40 -> data_in=0xCAFEF00D, wr_count=1, rd_count=1.
- Same-cycle read and write to 0x44 holding 0x11111111 with new data 0x22222222 -> data_in=0x11111111 that cycle; next read returns 0x22222222.
- Misaligned store to 0x42 with data 0xFFFFFFFF -> word 0x40 unchanged, misalign_err=1, wr_count unchanged.
- rst pulsed mid-LOAD after 2 of 4 beats -> FSM IDLE, cpu_hold=0, no ld_done, words 0..1 kept. With MEM_BOUNDS_CHECK_EN and DEPTH_WORDS=1024, read 0x1000 -> data_in=0xDEADBEEF, bounds_err=1.

Source files
------------

// File: rtl/cpu_mem_responder_if.sv
// CPU instruction/data ports, preload handshake and debug status of the
// memory responder. The CPU/loader side uses the master modport and the
// responder uses the slave modport.
`timescale 1ns/1ps

interface cpu_mem_responder_if #(
    parameter int unsigned AW    = 10,
    parameter int unsigned CNT_W = 16
);
    // CPU fetch port
    logic [31:0]      instr_addr;
    logic [31:0]      instruction;
    // CPU data port
    logic [31:0]      data_addr;
    logic [31:0]      data_out;
    logic [31:0]      data_in;
    logic             mem_write;
    logic             mem_read;
    // Preload port
    logic             ld_start;
    logic             ld_valid;
    logic             ld_ready;
    logic [AW-1:0]    ld_addr;
    logic [31:0]      ld_data;
    logic             ld_last;
    logic             ld_done;
    logic             cpu_hold;
    // Debug status
    logic [CNT_W-1:0] rd_count;
    logic [CNT_W-1:0] wr_count;
    logic             misalign_err;
    logic             bounds_err;

    modport master (
        output instr_addr, data_addr, data_out, mem_write, mem_read,
        output ld_start, ld_valid, ld_addr, ld_data, ld_last,
        input  instruction, data_in, ld_ready, ld_done, cpu_hold,
        input  rd_count, wr_count, misalign_err, bounds_err
    );

    modport slave (
        input  instr_addr, data_addr, data_out, mem_write, mem_read,
        input  ld_start, ld_valid, ld_addr, ld_data, ld_last,
        output instruction, data_in, ld_ready, ld_done, cpu_hold,
        output rd_count, wr_count, misalign_err, bounds_err
    );
endinterface

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the pipelined CPU: unified word-addressed RAM,
// combinational fetch/load, clocked stores, a preload FSM that holds the CPU
// while a program image is written, access counters and sticky error flags.
// Optional feature: define MEM_BOUNDS_CHECK_EN to flag and suppress CPU
// accesses at or above DEPTH_WORDS*4; otherwise addresses wrap.
`timescale 1ns/1ps

module cpu_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    cpu_mem_responder_if.slave bus
);

    localparam logic [31:0] OOB_WORD = 32'hDEAD_BEEF;

`ifdef MEM_BOUNDS_CHECK_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rd_count_q, rd_count_d;
    logic [CNT_W-1:0] wr_count_q, wr_count_d;
    logic             misalign_err_q, misalign_err_d;
    logic             bounds_err_q, bounds_err_d;

    logic             ld_ready;
    logic             ld_done;
    logic             cpu_hold;

    logic [31:0]      mem_q [DEPTH_WORDS];

    logic [AW-1:0]    instr_idx;
    logic [AW-1:0]    data_idx;
    logic             data_access;
    logic             data_misalign;
    logic             instr_oob;
    logic             data_oob;
    logic             cpu_wr_en;
    logic             ld_wr_en;

    // Address decode; the upper byte-address bits only matter for bounds checks
    assign instr_idx     = bus.instr_addr[AW+1:2];
    assign data_idx      = bus.data_addr[AW+1:2];
    assign data_access   = bus.mem_read | bus.mem_write;
    assign data_misalign = |bus.data_addr[1:0];
    assign instr_oob     = BOUNDS_EN & (|bus.instr_addr[31:AW+2]);
    assign data_oob      = BOUNDS_EN & (|bus.data_addr[31:AW+2]);

    // CPU stores are blocked while held; preload beats only land in LOAD
    assign cpu_wr_en = bus.mem_write & ~cpu_hold & ~data_misalign & ~data_oob;
    assign ld_wr_en  = (state_q == ST_LOAD) & bus.ld_valid;

    // Preload FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Preload FSM next state and decoded handshake/hold outputs
    always_comb begin
        state_d  = state_q;
        ld_ready = 1'b0;
        ld_done  = 1'b0;
        cpu_hold = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.ld_start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ld_ready = 1'b1;
                cpu_hold = 1'b1;
                if (bus.ld_valid && bus.ld_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                cpu_hold = 1'b1;
                ld_done  = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // RAM write port; contents intentionally survive rst
    always_ff @(posedge clk) begin
        if (ld_wr_en) begin
            mem_q[bus.ld_addr] <= bus.ld_data;
        end else if (cpu_wr_en) begin
            mem_q[data_idx] <= bus.data_out;
        end
    end

    // Counter and sticky-flag next values
    always_comb begin
        rd_count_d     = rd_count_q;
        wr_count_d     = wr_count_q;
        misalign_err_d = misalign_err_q;
        bounds_err_d   = bounds_err_q;
        if (bus.mem_read && !cpu_hold && (rd_count_q != '1)) begin
            rd_count_d = rd_count_q + CNT_W'(1);
        end
        if (cpu_wr_en && (wr_count_q != '1)) begin
            wr_count_d = wr_count_q + CNT_W'(1);
        end
        if (data_access && data_misalign) begin
            misalign_err_d = 1'b1;
        end
        if ((data_access && data_oob) || (!cpu_hold && instr_oob)) begin
            bounds_err_d = 1'b1;
        end
    end

    // Counter and sticky-flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count_q     <= '0;
            wr_count_q     <= '0;
            misalign_err_q <= 1'b0;
            bounds_err_q   <= 1'b0;
        end else begin
            rd_count_q     <= rd_count_d;
            wr_count_q     <= wr_count_d;
            misalign_err_q <= misalign_err_d;
            bounds_err_q   <= bounds_err_d;
        end
    end

    // Combinational read ports; the CPU samples them on the same edge
    always_comb begin
        bus.instruction = 32'h0;
        bus.data_in     = 32'h0;
        if (!cpu_hold) begin
            bus.instruction = instr_oob ? OOB_WORD : mem_q[instr_idx];
            if (bus.mem_read) begin
                bus.data_in = data_oob ? OOB_WORD : mem_q[data_idx];
            end
        end
    end

    assign bus.ld_ready     = ld_ready;
    assign bus.ld_done      = ld_done;
    assign bus.cpu_hold     = cpu_hold;
    assign bus.rd_count     = rd_count_q;
    assign bus.wr_count     = wr_count_q;
    assign bus.misalign_err = misalign_err_q;
    assign bus.bounds_err   = bounds_err_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: expected read/fetch words go
// into a scoreboard queue when the access is driven and are popped when the
// combinational output is sampled on the falling edge.
`timescale 1ns/1ps

module tb_cpu_mem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned AW    = 10;
    localparam int unsigned CNT_W = 4;

    logic clk;
    logic rst;

    cpu_mem_responder_if #(.AW(AW), .CNT_W(CNT_W)) bus ();

    cpu_mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .AW         (AW),
        .CNT_W      (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int ld_done_pulses = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;
    logic [31:0] img[3] = '{32'h0050_0093, 32'h0010_0113, 32'h0020_81B3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.ld_done === 1'b1) ld_done_pulses++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.instr_addr = 32'h0;
        bus.data_addr  = 32'h0;
        bus.data_out   = 32'h0;
        bus.mem_write  = 1'b0;
        bus.mem_read   = 1'b0;
        bus.ld_start   = 1'b0;
        bus.ld_valid   = 1'b0;
        bus.ld_addr    = '0;
        bus.ld_data    = 32'h0;
        bus.ld_last    = 1'b0;
    endtask

    task automatic push_read(input logic [31:0] addr, input logic [31:0] exp);
        exp_q.push_back(exp);
        bus.data_addr = addr;
        bus.mem_read  = 1'b1;
    endtask

    task automatic push_fetch(input logic [31:0] addr, input logic [31:0] exp);
        exp_q.push_back(exp);
        bus.instr_addr = addr;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({bus.ld_ready, bus.ld_done, bus.cpu_hold, bus.misalign_err, bus.bounds_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.ld_ready, bus.ld_done, bus.cpu_hold, bus.misalign_err, bus.bounds_err});
        end
        checks++;
        if ({bus.rd_count, bus.wr_count} !== '0) begin
            errors++;
            $display("FAIL reset_counts: got rd=%0d wr=%0d expected 0/0", bus.rd_count, bus.wr_count);
        end
    endtask

    task automatic test_preload();
        tick();
        bus.ld_start = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL preload_hold_in_idle: got %b expected 0", bus.cpu_hold);
        end
        tick();
        bus.ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_addr  = AW'(i);
            bus.ld_data  = img[i];
            bus.ld_last  = (i == 2);
            @(negedge clk);
            checks++;
            if ({bus.ld_ready, bus.cpu_hold, bus.instruction} !== {2'b11, 32'h0}) begin
                errors++;
                $display("FAIL preload_beat%0d: got ready=%b hold=%b instr=%h expected 1 1 00000000",
                         i, bus.ld_ready, bus.cpu_hold, bus.instruction);
            end
            tick();
        end
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.ld_ready, bus.cpu_hold, bus.ld_done} !== 3'b011) begin
            errors++;
            $display("FAIL preload_done_state: got %b expected 011",
                     {bus.ld_ready, bus.cpu_hold, bus.ld_done});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({bus.ld_ready, bus.cpu_hold, bus.ld_done} !== 3'b000 || ld_done_pulses != 1) begin
            errors++;
            $display("FAIL preload_back_to_idle: got %b pulses=%0d expected 000 pulses=1",
                     {bus.ld_ready, bus.cpu_hold, bus.ld_done}, ld_done_pulses);
        end
        for (int i = 2; i >= 0; i--) begin
            tick();
            push_fetch(32'(i * 4), img[i]);
            @(negedge clk);
            exp_w = exp_q.pop_front();
            checks++;
            if (bus.instruction !== exp_w) begin
                errors++;
                $display("FAIL preload_fetch_%0d: got %h expected %h", i * 4, bus.instruction, exp_w);
            end
        end
        bus.instr_addr = 32'h0;
    endtask

    task automatic test_store_load();
        tick();
        bus.mem_write = 1'b1;
        bus.data_addr = 32'h40;
        bus.data_out  = 32'hCAFE_F00D;
        tick();
        bus.mem_write = 1'b0;
        push_read(32'h40, 32'hCAFE_F00D);
        @(negedge clk);
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.data_in !== exp_w) begin
            errors++;
            $display("FAIL store_load_data: got %h expected %h", bus.data_in, exp_w);
        end
        tick();
        bus.mem_read = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.wr_count !== CNT_W'(1) || bus.rd_count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL store_load_counts: got wr=%0d rd=%0d expected 1/1", bus.wr_count, bus.rd_count);
        end
    endtask

    task automatic test_read_before_write();
        tick();
        bus.mem_write = 1'b1;
        bus.data_addr = 32'h44;
        bus.data_out  = 32'h1111_1111;
        tick();
        bus.data_out = 32'h2222_2222;
        push_read(32'h44, 32'h1111_1111);
        @(negedge clk);
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.data_in !== exp_w) begin
            errors++;
            $display("FAIL rbw_old_word: got %h expected %h", bus.data_in, exp_w);
        end
        tick();
        bus.mem_write = 1'b0;
        push_read(32'h44, 32'h2222_2222);
        @(negedge clk);
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.data_in !== exp_w) begin
            errors++;
            $display("FAIL rbw_new_word: got %h expected %h", bus.data_in, exp_w);
        end
        tick();
        bus.mem_read = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.wr_count !== CNT_W'(3) || bus.rd_count !== CNT_W'(3)) begin
            errors++;
            $display("FAIL rbw_counts: got wr=%0d rd=%0d expected 3/3", bus.wr_count, bus.rd_count);
        end
    endtask

    task automatic test_misaligned();
        tick();
        bus.mem_write = 1'b1;
        bus.data_addr = 32'h42;
        bus.data_out  = 32'hFFFF_FFFF;
        tick();
        bus.mem_write = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.misalign_err !== 1'b1 || bus.wr_count !== CNT_W'(3)) begin
            errors++;
            $display("FAIL misalign_store: got err=%b wr=%0d expected 1/3", bus.misalign_err, bus.wr_count);
        end
        push_read(32'h40, 32'hCAFE_F00D);
        @(negedge clk);
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.data_in !== exp_w) begin
            errors++;
            $display("FAIL misalign_word_kept: got %h expected %h", bus.data_in, exp_w);
        end
        tick();
        push_read(32'h41, 32'hCAFE_F00D);
        @(negedge clk);
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.data_in !== exp_w) begin
            errors++;
            $display("FAIL misalign_read_aligned: got %h expected %h", bus.data_in, exp_w);
        end
        tick();
        bus.mem_read = 1'b0;
    endtask

    task automatic test_reset_keeps_ram();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.rd_count, bus.wr_count, bus.misalign_err} !== '0) begin
            errors++;
            $display("FAIL rst_clears_status: got rd=%0d wr=%0d mis=%b expected 0",
                     bus.rd_count, bus.wr_count, bus.misalign_err);
        end
        tick();
        rst = 1'b0;
        push_fetch(32'h0, img[0]);
        push_read(32'h44, 32'h2222_2222);
        @(negedge clk);
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.instruction !== exp_w) begin
            errors++;
            $display("FAIL rst_keeps_fetch: got %h expected %h", bus.instruction, exp_w);
        end
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.data_in !== exp_w) begin
            errors++;
            $display("FAIL rst_keeps_data: got %h expected %h", bus.data_in, exp_w);
        end
        tick();
        bus.mem_read = 1'b0;
    endtask

    task automatic test_hold_blocks_cpu();
        // ld_valid in IDLE must not write
        bus.ld_valid = 1'b1;
        bus.ld_addr  = AW'(1);
        bus.ld_data  = 32'h1234_5678;
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start  = 1'b1;
        bus.mem_write = 1'b1;
        bus.mem_read  = 1'b1;
        bus.data_addr = 32'h40;
        bus.data_out  = 32'h0BAD_F00D;
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = AW'(5);
        bus.ld_data   = 32'h5555_5555;
        bus.ld_last   = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.data_in !== 32'h0) begin
            errors++;
            $display("FAIL hold_data_in_zero: got %h expected 00000000", bus.data_in);
        end
        tick();
        idle_inputs();
        tick();
        @(negedge clk);
        checks++;
        if (bus.cpu_hold !== 1'b0 || bus.wr_count !== CNT_W'(0) || bus.rd_count !== CNT_W'(1)
            || ld_done_pulses != 2) begin
            errors++;
            $display("FAIL hold_drops_cpu: got hold=%b wr=%0d rd=%0d pulses=%0d expected 0/0/1/2",
                     bus.cpu_hold, bus.wr_count, bus.rd_count, ld_done_pulses);
        end
        push_read(32'h40, 32'hCAFE_F00D);
        push_fetch(32'h14, 32'h5555_5555);
        @(negedge clk);
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.data_in !== exp_w) begin
            errors++;
            $display("FAIL hold_write_dropped: got %h expected %h", bus.data_in, exp_w);
        end
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.instruction !== exp_w) begin
            errors++;
            $display("FAIL hold_beat_written: got %h expected %h", bus.instruction, exp_w);
        end
        tick();
        bus.mem_read = 1'b0;
        push_fetch(32'h4, img[1]);
        @(negedge clk);
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.instruction !== exp_w) begin
            errors++;
            $display("FAIL idle_valid_ignored: got %h expected %h", bus.instruction, exp_w);
        end
    endtask

    task automatic test_mid_load_reset();
        tick();
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_addr  = AW'(i);
            bus.ld_data  = 32'hAAAA_0000 + 32'(i);
            bus.ld_last  = 1'b0;
            if (i < 2) tick();
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.ld_ready, bus.cpu_hold, bus.ld_done} !== 3'b000) begin
            errors++;
            $display("FAIL midload_rst_idle: got %b expected 000",
                     {bus.ld_ready, bus.cpu_hold, bus.ld_done});
        end
        idle_inputs();
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            push_fetch(32'(i * 4), (i < 2) ? 32'hAAAA_0000 + 32'(i) : img[2]);
            @(negedge clk);
            exp_w = exp_q.pop_front();
            checks++;
            if (bus.instruction !== exp_w) begin
                errors++;
                $display("FAIL midload_word%0d: got %h expected %h", i, bus.instruction, exp_w);
            end
            tick();
        end
        bus.instr_addr = 32'h0;
        checks++;
        if (ld_done_pulses != 2) begin
            errors++;
            $display("FAIL midload_no_done: got pulses=%0d expected 2", ld_done_pulses);
        end
    endtask

    task automatic test_bounds();
`ifdef MEM_BOUNDS_CHECK_EN
        tick();
        bus.mem_write = 1'b1;
        bus.data_addr = 32'h1040;
        bus.data_out  = 32'h7777_7777;
        tick();
        bus.mem_write = 1'b0;
        push_read(32'h1000, 32'hDEAD_BEEF);
        @(negedge clk);
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.data_in !== exp_w) begin
            errors++;
            $display("FAIL bounds_read: got %h expected %h", bus.data_in, exp_w);
        end
        tick();
        push_read(32'h40, 32'hCAFE_F00D);
        @(negedge clk);
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.data_in !== exp_w || bus.bounds_err !== 1'b1 || bus.wr_count !== CNT_W'(0)) begin
            errors++;
            $display("FAIL bounds_effects: got data=%h err=%b wr=%0d expected %h 1 0",
                     bus.data_in, bus.bounds_err, bus.wr_count, exp_w);
        end
`else
        tick();
        push_read(32'h1040, 32'hCAFE_F00D);
        @(negedge clk);
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.data_in !== exp_w) begin
            errors++;
            $display("FAIL wrap_read: got %h expected %h", bus.data_in, exp_w);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.bounds_err !== 1'b0) begin
            errors++;
            $display("FAIL bounds_err_tied: got %b expected 0", bus.bounds_err);
        end
`endif
        tick();
        bus.mem_read = 1'b0;
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.mem_write = 1'b1;
            bus.data_addr = 32'h80;
            bus.data_out  = 32'h100 + 32'(i);
            tick();
        end
        bus.mem_write = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.wr_count !== '1) begin
            errors++;
            $display("FAIL wr_saturate: got %0d expected %0d", bus.wr_count, {CNT_W{1'b1}});
        end
        for (int i = 0; i < 19; i++) begin
            bus.mem_read  = 1'b1;
            bus.data_addr = 32'h80;
            tick();
        end
        push_read(32'h80, 32'h113);
        @(negedge clk);
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.data_in !== exp_w) begin
            errors++;
            $display("FAIL saturate_last_write: got %h expected %h", bus.data_in, exp_w);
        end
        tick();
        bus.mem_read = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rd_count !== '1) begin
            errors++;
            $display("FAIL rd_saturate: got %0d expected %0d", bus.rd_count, {CNT_W{1'b1}});
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_preload();
        test_store_load();
        test_read_before_write();
        test_misaligned();
        test_reset_keeps_ram();
        test_hold_blocks_cpu();
        test_mid_load_reset();
        test_bounds();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
